// File: rtl/hsiao_secded_codec.sv
// Hsiao SECDED encoder/decoder pair with saturating error statistics.
// The encoder appends parity in the codeword MSBs. The decoder corrects
// single-bit errors and flags uncorrectable ones. Every output is registered.
module hsiao_secded_codec #(
   parameter int DataWidth = 32,
   parameter int CntWidth  = 16,
   localparam int ProtWidth = $clog2(DataWidth) + 2,
   localparam int CodeWidth = DataWidth + ProtWidth
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   // encoder
   input  logic                 enc_valid_i,
   input  logic [DataWidth-1:0] enc_data_i,
   output logic                 enc_valid_o,
   output logic [CodeWidth-1:0] enc_code_o,
   // decoder
   input  logic                 dec_valid_i,
   input  logic [CodeWidth-1:0] dec_code_i,
   output logic                 dec_valid_o,
   output logic [DataWidth-1:0] dec_data_o,
   output logic [ProtWidth-1:0] dec_syndrome_o,
   output logic [1:0]           dec_err_o,
   // statistics
   input  logic                 cnt_clear_i,
   output logic [CntWidth-1:0]  cnt_ce_o,
   output logic [CntWidth-1:0]  cnt_ue_o
);

   // ------------------------------------------------------------------
   // Elaboration-time construction of the H matrix
   // ------------------------------------------------------------------

   // Number of set bits in a small non-negative integer.
   function automatic int popcount(input int v);
      int c;
      c = 0;
      for (int b = 0; b < 31; b++) begin
         c += (v >> b) & 1;
      end
      return c;
   endfunction

   // Data columns: odd weights >= 3 in ascending weight and value, then
   // even weights >= 2 if the odd ones run out. Unit vectors are never
   // picked, so they stay reserved for the parity bits.
   function automatic logic [DataWidth*ProtWidth-1:0] gen_cols();
      logic [DataWidth*ProtWidth-1:0] cols;
      int idx;
      cols = '0;
      idx  = 0;
      for (int pass = 0; pass < 2; pass++) begin
         for (int w = (pass == 0) ? 3 : 2; w <= ProtWidth; w += 2) begin
            for (int v = 1; v < (1 << ProtWidth); v++) begin
               if (popcount(v) == w && idx < DataWidth) begin
                  cols[idx*ProtWidth +: ProtWidth] = v[ProtWidth-1:0];
                  idx++;
               end
            end
         end
      end
      return cols;
   endfunction

   // Transpose the columns into one data-bit mask per parity row.
   function automatic logic [ProtWidth*DataWidth-1:0] gen_rows(
      input logic [DataWidth*ProtWidth-1:0] cols
   );
      logic [ProtWidth*DataWidth-1:0] rows;
      rows = '0;
      for (int j = 0; j < ProtWidth; j++) begin
         for (int i = 0; i < DataWidth; i++) begin
            rows[j*DataWidth + i] = cols[i*ProtWidth + j];
         end
      end
      return rows;
   endfunction

   localparam logic [DataWidth*ProtWidth-1:0] HCols = gen_cols();
   localparam logic [ProtWidth*DataWidth-1:0] HRows = gen_rows(HCols);

   // ------------------------------------------------------------------
   // Datapath helpers
   // ------------------------------------------------------------------

   // Parity bit j is the XOR of the data bits selected by row j.
   function automatic logic [ProtWidth-1:0] calc_parity(
      input logic [DataWidth-1:0] d
   );
      logic [ProtWidth-1:0] p;
      for (int j = 0; j < ProtWidth; j++) begin
         p[j] = ^(d & HRows[j*DataWidth +: DataWidth]);
      end
      return p;
   endfunction

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CntWidth-1:0] sat_inc(
      input logic [CntWidth-1:0] v
   );
      return (v == {CntWidth{1'b1}}) ? v : v + 1'b1;
   endfunction

   // ------------------------------------------------------------------
   // Register state
   // ------------------------------------------------------------------
   logic                 enc_valid_q, enc_valid_d;
   logic [CodeWidth-1:0] enc_code_q,  enc_code_d;
   logic                 dec_valid_q, dec_valid_d;
   logic [DataWidth-1:0] dec_data_q,  dec_data_d;
   logic [ProtWidth-1:0] dec_syn_q,   dec_syn_d;
   logic [1:0]           dec_err_q,   dec_err_d;
   logic [CntWidth-1:0]  cnt_ce_q,    cnt_ce_d;
   logic [CntWidth-1:0]  cnt_ue_q,    cnt_ue_d;

   // Decoder combinational intermediates
   logic [ProtWidth-1:0] dec_par_in;
   logic [DataWidth-1:0] dec_data_in;
   logic [ProtWidth-1:0] syn;
   logic [DataWidth-1:0] flip;
   logic                 syn_is_unit;
   logic                 err_ce;
   logic                 err_ue;

   // Encoder next state: capture a new codeword only when valid.
   always_comb begin
      enc_valid_d = enc_valid_i;
      enc_code_d  = enc_code_q;
      if (enc_valid_i) begin
         enc_code_d = {calc_parity(enc_data_i), enc_data_i};
      end
   end

   // Syndrome evaluation and classification of the received codeword.
   always_comb begin
      dec_par_in  = dec_code_i[CodeWidth-1 -: ProtWidth];
      dec_data_in = dec_code_i[DataWidth-1:0];
      syn         = dec_par_in ^ calc_parity(dec_data_in);
      flip        = '0;
      for (int i = 0; i < DataWidth; i++) begin
         flip[i] = (syn == HCols[i*ProtWidth +: ProtWidth]);
      end
      // A unit-vector syndrome means the error sits in a parity bit.
      syn_is_unit = (syn != '0) && ((syn & (syn - 1'b1)) == '0);
      err_ce      = (|flip) || syn_is_unit;
      err_ue      = (syn != '0) && !err_ce;
   end

   // Decoder output and counter next state; clear beats increment.
   always_comb begin
      dec_valid_d = dec_valid_i;
      dec_data_d  = dec_data_q;
      dec_syn_d   = dec_syn_q;
      dec_err_d   = dec_err_q;
      cnt_ce_d    = cnt_ce_q;
      cnt_ue_d    = cnt_ue_q;
      if (dec_valid_i) begin
         dec_data_d = dec_data_in ^ flip;
         dec_syn_d  = syn;
         dec_err_d  = {err_ue, err_ce};
         if (err_ce) begin
            cnt_ce_d = sat_inc(cnt_ce_q);
         end
         if (err_ue) begin
            cnt_ue_d = sat_inc(cnt_ue_q);
         end
      end
      if (cnt_clear_i) begin
         cnt_ce_d = '0;
         cnt_ue_d = '0;
      end
   end

   // State registers; reset clears everything and drops in-flight words.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         enc_valid_q <= 1'b0;
         enc_code_q  <= '0;
         dec_valid_q <= 1'b0;
         dec_data_q  <= '0;
         dec_syn_q   <= '0;
         dec_err_q   <= '0;
         cnt_ce_q    <= '0;
         cnt_ue_q    <= '0;
      end else begin
         enc_valid_q <= enc_valid_d;
         enc_code_q  <= enc_code_d;
         dec_valid_q <= dec_valid_d;
         dec_data_q  <= dec_data_d;
         dec_syn_q   <= dec_syn_d;
         dec_err_q   <= dec_err_d;
         cnt_ce_q    <= cnt_ce_d;
         cnt_ue_q    <= cnt_ue_d;
      end
   end

   assign enc_valid_o    = enc_valid_q;
   assign enc_code_o     = enc_code_q;
   assign dec_valid_o    = dec_valid_q;
   assign dec_data_o     = dec_data_q;
   assign dec_syndrome_o = dec_syn_q;
   assign dec_err_o      = dec_err_q;
   assign cnt_ce_o       = cnt_ce_q;
   assign cnt_ue_o       = cnt_ue_q;

endmodule

// File: tb/tb_hsiao_secded_codec.sv
// Directed bench for hsiao_secded_codec at DataWidth 32, 1 and 69, plus a
// 32-bit instance with a 2-bit counter to reach saturation quickly.
module tb_hsiao_secded_codec;

   logic clk = 1'b0;
   logic rst_n;
   logic clr;
   always #5 clk = ~clk;

   // 32-bit lane (shared stimulus for u32 and usat)
   logic        e_v, d_v;
   logic [31:0] e_d;
   logic [38:0] d_c;
   logic        eo_v, do_v;
   logic [38:0] eo_c;
   logic [31:0] do_d;
   logic [6:0]  do_s;
   logic [1:0]  do_e;
   logic [15:0] ce, ue;
   logic        s_eo_v, s_do_v;
   logic [38:0] s_eo_c;
   logic [31:0] s_do_d;
   logic [6:0]  s_do_s;
   logic [1:0]  s_do_e;
   logic [1:0]  s_ce, s_ue;
   // 1-bit lane
   logic        e1_v, d1_v, e1o_v, d1o_v;
   logic [0:0]  e1_d, d1o_d;
   logic [2:0]  d1_c, e1o_c;
   logic [1:0]  d1o_s, d1o_e;
   logic [15:0] c1_ce, c1_ue;
   // 69-bit lane
   logic        e69_v, d69_v, e69o_v, d69o_v;
   logic [68:0] e69_d, d69o_d;
   logic [77:0] d69_c, e69o_c;
   logic [8:0]  d69o_s;
   logic [1:0]  d69o_e;
   logic [15:0] c69_ce, c69_ue;

   hsiao_secded_codec #(.DataWidth(32)) u32 (
      .clk_i(clk), .rst_ni(rst_n),
      .enc_valid_i(e_v), .enc_data_i(e_d), .enc_valid_o(eo_v), .enc_code_o(eo_c),
      .dec_valid_i(d_v), .dec_code_i(d_c), .dec_valid_o(do_v), .dec_data_o(do_d),
      .dec_syndrome_o(do_s), .dec_err_o(do_e),
      .cnt_clear_i(clr), .cnt_ce_o(ce), .cnt_ue_o(ue));

   hsiao_secded_codec #(.DataWidth(32), .CntWidth(2)) usat (
      .clk_i(clk), .rst_ni(rst_n),
      .enc_valid_i(e_v), .enc_data_i(e_d), .enc_valid_o(s_eo_v), .enc_code_o(s_eo_c),
      .dec_valid_i(d_v), .dec_code_i(d_c), .dec_valid_o(s_do_v), .dec_data_o(s_do_d),
      .dec_syndrome_o(s_do_s), .dec_err_o(s_do_e),
      .cnt_clear_i(clr), .cnt_ce_o(s_ce), .cnt_ue_o(s_ue));

   hsiao_secded_codec #(.DataWidth(1)) u1 (
      .clk_i(clk), .rst_ni(rst_n),
      .enc_valid_i(e1_v), .enc_data_i(e1_d), .enc_valid_o(e1o_v), .enc_code_o(e1o_c),
      .dec_valid_i(d1_v), .dec_code_i(d1_c), .dec_valid_o(d1o_v), .dec_data_o(d1o_d),
      .dec_syndrome_o(d1o_s), .dec_err_o(d1o_e),
      .cnt_clear_i(clr), .cnt_ce_o(c1_ce), .cnt_ue_o(c1_ue));

   hsiao_secded_codec #(.DataWidth(69)) u69 (
      .clk_i(clk), .rst_ni(rst_n),
      .enc_valid_i(e69_v), .enc_data_i(e69_d), .enc_valid_o(e69o_v), .enc_code_o(e69o_c),
      .dec_valid_i(d69_v), .dec_code_i(d69_c), .dec_valid_o(d69o_v), .dec_data_o(d69o_d),
      .dec_syndrome_o(d69o_s), .dec_err_o(d69o_e),
      .cnt_clear_i(clr), .cnt_ce_o(c69_ce), .cnt_ue_o(c69_ue));

   typedef struct {
      logic [31:0] data;
      logic [38:0] code;
   } enc_vec_t;

   typedef struct {
      logic [38:0] code;
      logic [31:0] data;
      logic [6:0]  syn;
      logic [1:0]  err;
   } dec_vec_t;

   int n_tests = 0;
   int n_fail  = 0;
   int ce_m, ue_m, sce_m, sue_m;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_counters();
      check("cnt_ce", ce, ce_m);
      check("cnt_ue", ue, ue_m);
      check("sat_ce", s_ce, sce_m);
      check("sat_ue", s_ue, sue_m);
   endtask

   // Expected-count bookkeeping for one accepted decode.
   task automatic count_err(input logic [1:0] err);
      if (err[0]) begin ce_m++; if (sce_m < 3) sce_m++; end
      if (err[1]) begin ue_m++; if (sue_m < 3) sue_m++; end
   endtask

   enc_vec_t ev[7];
   dec_vec_t dv[12];

   initial begin
      logic [31:0] r;
      logic [38:0] code, fl;
      logic [68:0] r69;
      logic [77:0] code69, fl78;
      int b;

      // Data columns for 7 parity bits start 7,11,13,14,19,21,..;
      // bit 17 -> 50, bit 20 -> 67, bit 31 -> 98.
      ev[0] = '{32'h0000_0000, {7'd0,  32'h0000_0000}};
      ev[1] = '{32'h0000_0001, {7'd7,  32'h0000_0001}};
      ev[2] = '{32'h0000_0003, {7'd12, 32'h0000_0003}};
      ev[3] = '{32'h0000_0020, {7'd21, 32'h0000_0020}};
      ev[4] = '{32'h0010_0000, {7'd67, 32'h0010_0000}};
      ev[5] = '{32'h8000_0000, {7'd98, 32'h8000_0000}};
      ev[6] = '{32'h0002_0008, {7'd60, 32'h0002_0008}};

      dv[0]  = '{{7'd0,   32'h0000_0000}, 32'h0000_0000, 7'd0,   2'b00};
      dv[1]  = '{{7'd7,   32'h0000_0001}, 32'h0000_0001, 7'd0,   2'b00};
      dv[2]  = '{{7'd7,   32'h0000_0021}, 32'h0000_0001, 7'd21,  2'b01};
      dv[3]  = '{{7'd1,   32'h0000_0000}, 32'h0000_0000, 7'd1,   2'b01};
      dv[4]  = '{{7'd21,  32'h0000_0000}, 32'h0000_0020, 7'd21,  2'b01};
      dv[5]  = '{{7'd0,   32'h0002_0008}, 32'h0002_0008, 7'd60,  2'b10};
      dv[6]  = '{{7'd3,   32'h0000_0000}, 32'h0000_0000, 7'd3,   2'b10};
      dv[7]  = '{{7'd100, 32'h0000_0000}, 32'h0000_0000, 7'd100, 2'b10};
      dv[8]  = '{{7'd34,  32'h8000_0000}, 32'h8000_0000, 7'd64,  2'b01};
      dv[9]  = '{{7'd31,  32'h0000_0000}, 32'h0000_0000, 7'd31,  2'b10};
      dv[10] = '{{7'd0,   32'h8000_0000}, 32'h0000_0000, 7'd98,  2'b01};
      dv[11] = '{{7'd12,  32'h0000_0001}, 32'h0000_0003, 7'd11,  2'b01};

      rst_n = 1'b0; clr = 1'b0;
      e_v = 0; e_d = '0; d_v = 0; d_c = '0;
      e1_v = 0; e1_d = '0; d1_v = 0; d1_c = '0;
      e69_v = 0; e69_d = '0; d69_v = 0; d69_c = '0;
      ce_m = 0; ue_m = 0; sce_m = 0; sue_m = 0;
      tick(); tick();

      // Reset state
      check("rst_enc_valid", eo_v, 0);
      check("rst_enc_code", eo_c, 0);
      check("rst_dec_valid", do_v, 0);
      check("rst_dec_err", do_e, 0);
      check_counters();
      rst_n = 1'b1;

      // 32-bit encoder table
      for (int i = 0; i < 7; i++) begin
         e_v = 1'b1; e_d = ev[i].data;
         tick();
         check($sformatf("enc32_code[%0d]", i), eo_c, ev[i].code);
         check($sformatf("enc32_valid[%0d]", i), eo_v, 1);
      end
      // Encoder holds its code while idle
      e_v = 1'b0; e_d = 32'h1234_5678;
      tick();
      check("enc32_hold_code", eo_c, ev[6].code);
      check("enc32_hold_valid", eo_v, 0);

      // 32-bit decoder table
      for (int i = 0; i < 12; i++) begin
         d_v = 1'b1; d_c = dv[i].code;
         tick();
         count_err(dv[i].err);
         check($sformatf("dec32_data[%0d]", i), do_d, dv[i].data);
         check($sformatf("dec32_syn[%0d]", i), do_s, dv[i].syn);
         check($sformatf("dec32_err[%0d]", i), do_e, dv[i].err);
         check($sformatf("dec32_valid[%0d]", i), do_v, 1);
         check_counters();
      end
      // Decoder outputs and counters hold while idle, even for a bad word
      d_v = 1'b0; d_c = {7'd3, 32'h0};
      tick();
      check("dec32_hold_data", do_d, dv[11].data);
      check("dec32_hold_err", do_e, dv[11].err);
      check("dec32_hold_valid", do_v, 0);
      check_counters();

      // Random round trips, then random single-bit flips
      for (int i = 0; i < 1000; i++) begin
         r = $urandom();
         e_v = 1'b1; e_d = r;
         tick();
         code = eo_c;
         e_v = 1'b0; d_v = 1'b1; d_c = code;
         tick();
         d_v = 1'b0;
         check("rt32_data", do_d, r);
         check("rt32_err", do_e, 0);
      end
      for (int i = 0; i < 200; i++) begin
         r = $urandom();
         b = $urandom_range(38, 0);
         e_v = 1'b1; e_d = r;
         tick();
         fl = 39'd1 << b;
         e_v = 1'b0; d_v = 1'b1; d_c = eo_c ^ fl;
         tick();
         d_v = 1'b0;
         count_err(2'b01);
         check("flip32_data", do_d, r);
         check("flip32_err", do_e, 2'b01);
      end
      check_counters();

      // Clear in the same cycle as an uncorrectable error
      d_v = 1'b1; d_c = {7'd0, 32'h0002_0008}; clr = 1'b1;
      tick();
      d_v = 1'b0; clr = 1'b0;
      ce_m = 0; ue_m = 0; sce_m = 0; sue_m = 0;
      check("clr_err", do_e, 2'b10);
      check_counters();

      // 1-bit lane: column 2'b11
      e1_v = 1'b1; e1_d = 1'b1;
      tick();
      check("enc1_one", e1o_c, 3'b111);
      check("enc1_valid", e1o_v, 1);
      e1_d = 1'b0;
      tick();
      check("enc1_zero", e1o_c, 3'b000);
      e1_v = 1'b0;
      d1_v = 1'b1; d1_c = 3'b111;
      tick();
      check("dec1_clean_data", d1o_d, 1); check("dec1_clean_err", d1o_e, 0);
      d1_c = 3'b110;
      tick();
      check("dec1_dflip_data", d1o_d, 1); check("dec1_dflip_syn", d1o_s, 2'b11);
      check("dec1_dflip_err", d1o_e, 2'b01);
      d1_c = 3'b101;
      tick();
      check("dec1_pflip_data", d1o_d, 1); check("dec1_pflip_syn", d1o_s, 2'b01);
      check("dec1_pflip_err", d1o_e, 2'b01);
      d1_c = 3'b001;
      tick();
      check("dec1_zflip_data", d1o_d, 0); check("dec1_zflip_err", d1o_e, 2'b01);
      d1_v = 1'b0;

      // 69-bit lane: bit 0 -> 9'd7, bit 68 -> 9'd292
      e69_v = 1'b1; e69_d = 69'd1;
      tick();
      check("enc69_bit0", e69o_c, {9'd7, 69'd1});
      e69_d = 69'd1 << 68;
      tick();
      check("enc69_bit68", e69o_c, {9'd292, 69'd1 << 68});
      r69 = {$urandom(), $urandom(), $urandom()};
      e69_d = r69;
      tick();
      code69 = e69o_c;
      e69_v = 1'b0;
      d69_v = 1'b1; d69_c = code69;
      tick();
      check("rt69_data", d69o_d, r69);
      check("rt69_err", d69o_e, 0);
      for (int i = 0; i < 78; i++) begin
         fl78 = 78'd1 << i;
         d69_c = code69 ^ fl78;
         tick();
         check($sformatf("flip69_data[%0d]", i), d69o_d, r69);
         check($sformatf("flip69_err[%0d]", i), d69o_e, 2'b01);
      end
      d69_v = 1'b0;

      // Build up some counts, then reset mid-stream with valids high
      d_v = 1'b1; d_c = {7'd3, 32'h0};
      tick();
      e_v = 1'b1; e_d = 32'hFFFF_FFFF; e1_v = 1'b1; e69_v = 1'b1; d1_v = 1'b1;
      d1_c = 3'b110; d69_v = 1'b1; d69_c = code69 ^ 78'd1;
      rst_n = 1'b0;
      tick();
      ce_m = 0; ue_m = 0; sce_m = 0; sue_m = 0;
      check("mrst_enc_valid", eo_v, 0);
      check("mrst_enc_code", eo_c, 0);
      check("mrst_dec_valid", do_v, 0);
      check("mrst_dec_data", do_d, 0);
      check("mrst_dec_syn", do_s, 0);
      check("mrst_dec_err", do_e, 0);
      check_counters();
      check("mrst_1_code", e1o_c, 0);
      check("mrst_1_err", d1o_e, 0);
      check("mrst_69_data", d69o_d, 0);
      check("mrst_69_valid", d69o_v, 0);
      rst_n = 1'b1;
      e_v = 0; d_v = 0; e1_v = 0; d1_v = 0; e69_v = 0; d69_v = 0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
